// File: rtl/sram_controller_pkg.sv
// Shared definitions for the cache-side SRAM controller: FSM encoding,
// default address map and halfword counts per transfer type.
package sram_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Byte address that maps onto SRAM halfword 0
    localparam int unsigned BASE_ADDR_DEFAULT = 1024;

    // Halfwords moved per 32-bit word write and per 64-bit line read
    localparam int HW_PER_WORD = 2;
    localparam int HW_PER_LINE = 4;

endpackage

// File: rtl/sram_controller.sv
// Cache-to-SRAM responder: splits 32-bit word writes and 64-bit line reads
// into halfword slots on a 16-bit asynchronous SRAM and pulses ready once
// the last slot has finished.
module sram_controller
    import sram_controller_pkg::*;
#(
    parameter int unsigned BASE_ADDR     = BASE_ADDR_DEFAULT,
    parameter int unsigned ACCESS_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        W_EN,
    input  logic        R_EN,
    input  logic [31:0] address,
    input  logic [31:0] data_in,
    output logic [63:0] data_out,
    output logic        ready,
    inout  wire  [15:0] SRAM_DQ,
    output logic [17:0] SRAM_ADDR,
    output logic        SRAM_WE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_CE_N,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N
);

    // Slot counter runs 0..ACCESS_CYCLES; the final value is the hold cycle
    localparam int CNT_W = (ACCESS_CYCLES > 0) ? $clog2(ACCESS_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT      = CNT_W'(ACCESS_CYCLES);
    localparam logic [1:0]       LAST_WORD_IDX = 2'(HW_PER_WORD - 1);
    localparam logic [1:0]       LAST_LINE_IDX = 2'(HW_PER_LINE - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [17:0]      base_q, base_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [63:0]      data_out_q, data_out_d;

    logic        accept;
    logic        slot_end;
    logic [31:0] off;
    logic        unused_off;

    assign off        = address - 32'(BASE_ADDR);
    assign unused_off = ^{off[31:19], off[1:0]};
    assign slot_end   = (cnt_q == LAST_CNT);

    // Next-state logic: slot/halfword sequencing for both transfer types
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        accept  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (W_EN) begin
                    state_d = ST_WRITE;
                    accept  = 1'b1;
                end else if (R_EN) begin
                    state_d = ST_READ;
                    accept  = 1'b1;
                end
            end
            ST_WRITE: begin
                if (slot_end) begin
                    cnt_d = '0;
                    if (idx_q == LAST_WORD_IDX) begin
                        state_d = ST_DONE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_READ: begin
                if (slot_end) begin
                    cnt_d = '0;
                    if (idx_q == LAST_LINE_IDX) begin
                        state_d = ST_DONE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    // Request latching and read-data capture on the last cycle of each read slot
    always_comb begin
        base_d     = base_q;
        wdata_d    = wdata_q;
        data_out_d = data_out_q;
        if (accept) begin
            base_d  = W_EN ? {off[18:2], 1'b0} : {off[18:3], 2'b00};
            wdata_d = data_in;
        end
        if (state_q == ST_READ && slot_end) begin
            data_out_d[{idx_q, 4'b0000} +: 16] = SRAM_DQ;
        end
    end

    // Control registers and returned line data, cleared asynchronously
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            data_out_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            data_out_q <= data_out_d;
        end
    end

    // Request address/data holding registers (only meaningful while busy)
    always_ff @(posedge clk) begin
        base_q  <= base_d;
        wdata_q <= wdata_d;
    end

    // Strobes are decoded from the state register so an async reset
    // releases WE_N and the DQ drivers in the same timestep.
    assign SRAM_ADDR = (state_q == ST_READ || state_q == ST_WRITE)
                     ? base_q + {16'd0, idx_q} : 18'd0;
    assign SRAM_WE_N = !(state_q == ST_WRITE && !slot_end);
    assign SRAM_OE_N = !(state_q == ST_READ);
    assign SRAM_DQ   = (state_q == ST_WRITE)
                     ? (idx_q[0] ? wdata_q[31:16] : wdata_q[15:0]) : 16'hzzzz;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign ready     = (state_q == ST_DONE);
    assign data_out  = data_out_q;

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: behavioural SRAM, a transaction-level model
// checked against the DUT every cycle, and directed scenarios with
// hand-computed expectations.
module tb_sram_controller;

    localparam int AC = 1;
    localparam int S  = AC + 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        W_EN, R_EN;
    logic [31:0] address, data_in;
    logic [63:0] data_out;
    logic        ready;
    wire  [15:0] SRAM_DQ;
    logic [17:0] SRAM_ADDR;
    logic        SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N;

    logic        W_EN3, R_EN3;
    logic [31:0] address3, data_in3;
    logic [63:0] data_out3;
    logic        ready3;
    wire  [15:0] SRAM_DQ3;
    logic [17:0] SRAM_ADDR3;
    logic        SRAM_WE_N3, SRAM_OE_N3, SRAM_CE_N3, SRAM_UB_N3, SRAM_LB_N3;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sram_controller #(.BASE_ADDR(1024), .ACCESS_CYCLES(AC)) dut (
        .clk(clk), .rst(rst), .W_EN(W_EN), .R_EN(R_EN), .address(address),
        .data_in(data_in), .data_out(data_out), .ready(ready), .SRAM_DQ(SRAM_DQ),
        .SRAM_ADDR(SRAM_ADDR), .SRAM_WE_N(SRAM_WE_N), .SRAM_OE_N(SRAM_OE_N),
        .SRAM_CE_N(SRAM_CE_N), .SRAM_UB_N(SRAM_UB_N), .SRAM_LB_N(SRAM_LB_N)
    );

    sram_controller #(.BASE_ADDR(1024), .ACCESS_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst), .W_EN(W_EN3), .R_EN(R_EN3), .address(address3),
        .data_in(data_in3), .data_out(data_out3), .ready(ready3), .SRAM_DQ(SRAM_DQ3),
        .SRAM_ADDR(SRAM_ADDR3), .SRAM_WE_N(SRAM_WE_N3), .SRAM_OE_N(SRAM_OE_N3),
        .SRAM_CE_N(SRAM_CE_N3), .SRAM_UB_N(SRAM_UB_N3), .SRAM_LB_N(SRAM_LB_N3)
    );

    // Behavioural 256K x 16 asynchronous SRAM; default contents A000^addr
    logic [15:0] mem [0:262143];
    logic        pl_en;
    logic [17:0] pl_a;
    logic [15:0] pl_d;

    assign SRAM_DQ  = (!SRAM_OE_N && SRAM_WE_N) ? mem[SRAM_ADDR] : 16'hzzzz;
    // Second SRAM behaves as a fixed pattern ROM for the long-access instance
    assign SRAM_DQ3 = (!SRAM_OE_N3) ? (SRAM_ADDR3[15:0] ^ 16'h5A5A) : 16'hzzzz;

    initial begin
        for (int i = 0; i < 262144; i++) mem[i] = 16'hA000 ^ 16'(i);
        forever begin
            @(negedge clk);
            if (pl_en) mem[pl_a] = pl_d;
            else if (!SRAM_WE_N) mem[SRAM_ADDR] = SRAM_DQ;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Transaction-level reference: request accepted in idle occupies N slots
    // of S cycles, then one ready cycle; reads take reference memory contents.
    logic [15:0] ref_mem [0:262143];
    bit          m_busy;
    bit          m_wr;
    int          m_c;
    logic [17:0] m_base;
    logic [31:0] m_wdata;
    logic [63:0] m_dout;
    logic [31:0] m_off;

    initial begin
        int nslot, j, p;
        for (int i = 0; i < 262144; i++) ref_mem[i] = 16'hA000 ^ 16'(i);
        m_busy = 0; m_c = 0; m_wr = 0; m_dout = '0; m_base = '0; m_wdata = '0;
        forever begin
            @(posedge clk);
            if (pl_en) ref_mem[pl_a] = pl_d;
            if (!rst) begin
                m_busy = 0;
                m_dout = '0;
            end else if (m_busy) begin
                nslot = m_wr ? 2 : 4;
                if (m_c < nslot * S && (m_c % S) == S - 1) begin
                    j = m_c / S;
                    if (m_wr) ref_mem[18'(m_base + 18'(j))] = m_wdata[16*j +: 16];
                    else      m_dout[16*j +: 16] = ref_mem[18'(m_base + 18'(j))];
                end
                if (m_c == nslot * S) m_busy = 0;
                else m_c++;
            end else if (W_EN || R_EN) begin
                m_busy  = 1;
                m_c     = 0;
                m_wr    = W_EN;
                m_off   = address - 32'd1024;
                m_base  = W_EN ? {m_off[18:2], 1'b0} : {m_off[18:3], 2'b00};
                m_wdata = data_in;
            end

            @(negedge clk);
            if (!rst) begin
                m_busy = 0;
                m_dout = '0;
                chk("rst_ready", ready, 0);
                chk("rst_we_n", SRAM_WE_N, 1);
                chk("rst_oe_n", SRAM_OE_N, 1);
                chk("rst_addr", SRAM_ADDR, 0);
                chk("rst_data_out", data_out, 0);
            end else begin
                nslot = m_wr ? 2 : 4;
                if (m_busy && m_c < nslot * S) begin
                    j = m_c / S;
                    p = m_c % S;
                    chk("ready", ready, 0);
                    chk("sram_addr", SRAM_ADDR, 18'(m_base + 18'(j)));
                    chk("we_n", SRAM_WE_N, (m_wr && p < AC) ? 1'b0 : 1'b1);
                    chk("oe_n", SRAM_OE_N, m_wr ? 1'b1 : 1'b0);
                    if (m_wr) chk("dq_write", SRAM_DQ, m_wdata[16*j +: 16]);
                end else begin
                    chk("ready", ready, m_busy ? 1'b1 : 1'b0);
                    chk("we_n", SRAM_WE_N, 1);
                    chk("oe_n", SRAM_OE_N, 1);
                end
                chk("data_out", data_out, m_dout);
            end
        end
    end

    logic [17:0] rq[$];
    logic [17:0] wq[$];

    task automatic do_req(input logic wr, input logic rd, input logic [31:0] a,
                          input logic [31:0] d, output int lat);
        @(negedge clk);
        #1;
        W_EN = wr; R_EN = rd; address = a; data_in = d;
        rq.delete(); wq.delete();
        lat = -1;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            if (!SRAM_OE_N && (rq.size() == 0 || rq[$] != SRAM_ADDR)) rq.push_back(SRAM_ADDR);
            if (!SRAM_WE_N && (wq.size() == 0 || wq[$] != SRAM_ADDR)) wq.push_back(SRAM_ADDR);
            if (ready) begin
                lat = n;
                break;
            end
        end
        if (lat < 0) begin
            n_cmp++; n_bad++;
            $display("FAIL req_timeout: got no ready, expected ready within 100 cycles");
        end
        #1;
        W_EN = 0; R_EN = 0;
    endtask

    task automatic preload(input logic [17:0] a, input logic [15:0] d);
        @(negedge clk);
        #1;
        pl_a = a; pl_d = d; pl_en = 1;
        @(negedge clk);
        #1;
        pl_en = 0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, pulses, p1, p2;
        int hold [4];
        logic [63:0] prev;
        rst = 0; W_EN = 0; R_EN = 0; address = 0; data_in = 0;
        W_EN3 = 0; R_EN3 = 0; address3 = 0; data_in3 = 0;
        pl_en = 0; pl_a = 0; pl_d = 0;

        repeat (3) @(negedge clk);
        chk("reset_ready", ready, 0);
        chk("reset_data_out", data_out, 0);
        chk("reset_addr", SRAM_ADDR, 0);
        chk("reset_we_n", SRAM_WE_N, 1);
        chk("reset_oe_n", SRAM_OE_N, 1);
        chk("tied_enables", {SRAM_CE_N, SRAM_UB_N, SRAM_LB_N}, 0);
        #1 rst = 1;

        // Word write then line read back
        do_req(1, 0, 32'd1024, 32'hDEADBEEF, lat);
        chk("write_latency", lat, 5);
        chk("write_hw0", mem[0], 16'hBEEF);
        chk("write_hw1", mem[1], 16'hDEAD);
        chk("write_addr_count", wq.size(), 2);
        if (wq.size() == 2) chk("write_addrs", {wq[0], wq[1]}, {18'd0, 18'd1});
        do_req(0, 1, 32'd1024, 32'd0, lat);
        chk("read_latency", lat, 9);
        chk("readback", data_out, 64'hA003_A002_DEAD_BEEF);

        // Line alignment: byte 1036 falls in the line at halfwords 4..7
        preload(18'd4, 16'h1111);
        preload(18'd5, 16'h2222);
        preload(18'd6, 16'h3333);
        preload(18'd7, 16'h4444);
        do_req(0, 1, 32'd1036, 32'd0, lat);
        chk("align_latency", lat, 9);
        chk("align_addr_count", rq.size(), 4);
        if (rq.size() == 4)
            chk("align_addrs", {rq[0], rq[1], rq[2], rq[3]}, {18'd4, 18'd5, 18'd6, 18'd7});
        chk("align_data", data_out, 64'h4444_3333_2222_1111);

        // Both enables high: the write wins and the line buffer is untouched
        prev = data_out;
        do_req(1, 1, 32'd1032, 32'h0000_00A5, lat);
        chk("simul_latency", lat, 5);
        chk("simul_no_read", rq.size(), 0);
        chk("simul_addr_count", wq.size(), 2);
        if (wq.size() == 2) chk("simul_addrs", {wq[0], wq[1]}, {18'd4, 18'd5});
        chk("simul_hw4", mem[4], 16'h00A5);
        chk("simul_hw5", mem[5], 16'h0000);
        chk("simul_data_out", data_out, 64'h4444_3333_2222_1111);
        chk("simul_data_kept", data_out, prev);

        // Four-cycle slots on the second instance
        @(negedge clk);
        #1 R_EN3 = 1; address3 = 32'd1024;
        for (int k = 0; k < 4; k++) hold[k] = 0;
        lat = -1;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            if (!SRAM_OE_N3 && SRAM_ADDR3 < 18'd4) hold[SRAM_ADDR3[1:0]]++;
            if (ready3) begin
                lat = n;
                break;
            end
        end
        #1 R_EN3 = 0;
        chk("ac3_latency", lat, 17);
        chk("ac3_hold0", hold[0], 4);
        chk("ac3_hold1", hold[1], 4);
        chk("ac3_hold2", hold[2], 4);
        chk("ac3_hold3", hold[3], 4);
        chk("ac3_data", data_out3, 64'h5A59_5A58_5A5B_5A5A);

        // Reset during write slot 0 while WE_N is low
        @(negedge clk);
        #1 W_EN = 1; address = 32'd1064; data_in = 32'h1234_5678;
        @(posedge clk);
        #2;
        chk("midrst_we_low_before", SRAM_WE_N, 0);
        W_EN = 0;
        rst = 0;
        #1;
        chk("midrst_we_n", SRAM_WE_N, 1);
        chk("midrst_oe_n", SRAM_OE_N, 1);
        chk("midrst_ready", ready, 0);
        chk("midrst_addr", SRAM_ADDR, 0);
        repeat (2) @(negedge clk);
        #1 rst = 1;
        pulses = 0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (ready) pulses++;
        end
        chk("midrst_no_ready", pulses, 0);
        chk("midrst_hw20", mem[20], 16'hA014);

        // Back-to-back reads with R_EN held through DONE
        @(negedge clk);
        #1 R_EN = 1; address = 32'd1040;
        pulses = 0; p1 = 0; p2 = 0;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (ready) begin
                pulses++;
                if (pulses == 1) p1 = n;
                if (pulses == 2) begin
                    p2 = n;
                    #1 R_EN = 0;
                end
            end
        end
        R_EN = 0;
        chk("b2b_pulses", pulses, 2);
        chk("b2b_first", p1, 9);
        chk("b2b_second", p2, 19);
        chk("b2b_data", data_out, 64'hA00B_A00A_A009_A008);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
